// File: rtl/store_combine_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_combine_buffer_pkg
// Description : Shared LC-3b types and state encoding for the store combine buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package store_combine_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [255:0] lc3b_burst;
    typedef logic [10:0]  lc3b_line_tag;
    typedef logic [31:0]  lc3b_byte_mask;
    typedef logic [3:0]   lc3b_word_idx;

    typedef enum logic [1:0] {
        SB_EMPTY   = 2'd0,
        SB_COLLECT = 2'd1,
        SB_DRAIN   = 2'd2
    } store_buf_state_t;

endpackage : store_combine_buffer_pkg
`default_nettype wire

// File: rtl/store_combine_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_combine_buffer_if
// Description : CPU store port, flush and line drain port of the store combine buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_combine_buffer_if;
    import store_combine_buffer_pkg::*;

    logic          cpu_write;
    lc3b_word      cpu_address;
    lc3b_word      cpu_wdata;
    logic [1:0]    cpu_mem_byte_enable;
    logic          cpu_resp;
    logic          flush;
    logic          drain_valid;
    logic          drain_ready;
    lc3b_line_tag  drain_tag;
    lc3b_burst     drain_line;
    lc3b_byte_mask drain_mask;
    logic          empty;

    modport slave (
        input  cpu_write, cpu_address, cpu_wdata, cpu_mem_byte_enable, flush, drain_ready,
        output cpu_resp, drain_valid, drain_tag, drain_line, drain_mask, empty
    );

    modport master (
        output cpu_write, cpu_address, cpu_wdata, cpu_mem_byte_enable, flush, drain_ready,
        input  cpu_resp, drain_valid, drain_tag, drain_line, drain_mask, empty
    );

endinterface : store_combine_buffer_if
`default_nettype wire

// File: rtl/store_combine_buffer_line_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : line_byte_merge
// Description : Combinational merge of one 16-bit store into a 32-byte line and mask.
// Revision    : 1.0 - initial release
// ============================================================================
module line_byte_merge
    import store_combine_buffer_pkg::*;
(
    input  lc3b_burst     line,
    input  lc3b_byte_mask mask,
    input  lc3b_word_idx  word_idx,
    input  lc3b_word      data,
    input  logic [1:0]    byte_en,
    output lc3b_burst     next_line,
    output lc3b_byte_mask next_mask
);

    always_comb begin
        next_line = line;
        next_mask = mask;
        if (byte_en[0]) begin
            next_line[{word_idx, 4'd0} +: 8] = data[7:0];
            next_mask[{word_idx, 1'b0}]      = 1'b1;
        end
        if (byte_en[1]) begin
            next_line[{word_idx, 4'd8} +: 8] = data[15:8];
            next_mask[{word_idx, 1'b1}]      = 1'b1;
        end
    end

endmodule : line_byte_merge
`default_nettype wire

// File: rtl/store_combine_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_combine_buffer
// Description : Single-line write-combining buffer draining merged lines to L1.
//               Define STORE_BUF_TIMEOUT_EN to enable the idle-timeout drain.
// Revision    : 1.0 - initial release
// ============================================================================
module store_combine_buffer
    import store_combine_buffer_pkg::*;
#(
    parameter int unsigned IDLE_LIMIT = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    store_combine_buffer_if.slave bus
);

    store_buf_state_t r_state;
    lc3b_burst        r_line;
    lc3b_byte_mask    r_mask;
    lc3b_line_tag     r_tag;

    lc3b_burst        w_base_line;
    lc3b_byte_mask    w_base_mask;
    lc3b_burst        w_merge_line;
    lc3b_byte_mask    w_merge_mask;
    logic             w_tag_hit;
    logic             w_accept;
    logic             w_timeout;
    logic             w_leave;

    if ((IDLE_LIMIT < 1) || (IDLE_LIMIT > 255)) begin : g_bad_idle_limit
        $error("IDLE_LIMIT must be in 1..255");
    end

    assign w_tag_hit = (bus.cpu_address[15:5] == r_tag);
    assign w_accept  = bus.cpu_write &
                       ((r_state == SB_EMPTY) | ((r_state == SB_COLLECT) & w_tag_hit));
    // Conflicting store, flush or timeout all end collection
    assign w_leave   = bus.flush | (bus.cpu_write & ~w_accept) | w_timeout;

    // The first store of a line merges into a clean line
    assign w_base_line = (r_state == SB_EMPTY) ? '0 : r_line;
    assign w_base_mask = (r_state == SB_EMPTY) ? '0 : r_mask;

    line_byte_merge u_merge (
        .line      (w_base_line),
        .mask      (w_base_mask),
        .word_idx  (bus.cpu_address[4:1]),
        .data      (bus.cpu_wdata),
        .byte_en   (bus.cpu_mem_byte_enable),
        .next_line (w_merge_line),
        .next_mask (w_merge_mask)
    );

`ifdef STORE_BUF_TIMEOUT_EN
    logic [7:0] r_idle_cnt;

    assign w_timeout = (r_state == SB_COLLECT) & ~w_accept & (r_idle_cnt == 8'(IDLE_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle_cnt <= 8'd0;
        end else if ((r_state != SB_COLLECT) || w_accept || w_leave) begin
            r_idle_cnt <= 8'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SB_EMPTY;
            r_line  <= '0;
            r_mask  <= '0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                SB_EMPTY: begin
                    if (w_accept) begin
                        r_tag   <= bus.cpu_address[15:5];
                        r_line  <= w_merge_line;
                        r_mask  <= w_merge_mask;
                        r_state <= SB_COLLECT;
                    end
                end
                SB_COLLECT: begin
                    if (w_accept) begin
                        r_line <= w_merge_line;
                        r_mask <= w_merge_mask;
                    end
                    if (w_leave) begin
                        r_state <= SB_DRAIN;
                    end
                end
                SB_DRAIN: begin
                    if (bus.drain_ready) begin
                        r_line  <= '0;
                        r_mask  <= '0;
                        r_state <= SB_EMPTY;
                    end
                end
                default: r_state <= SB_EMPTY;
            endcase
        end
    end

    assign bus.cpu_resp    = w_accept;
    assign bus.drain_valid = (r_state == SB_DRAIN);
    assign bus.drain_tag   = r_tag;
    assign bus.drain_line  = r_line;
    assign bus.drain_mask  = r_mask;
    assign bus.empty       = (r_state == SB_EMPTY);

endmodule : store_combine_buffer
`default_nettype wire
